// File: rtl/pulse_sched.sv
// Round-robin scheduler that lends one shared pulse divider to two requesters,
// programs its divide value, restarts it, and counts go pulses until each wait completes.
module pulse_sched #(
    parameter int CW = 26,
    parameter int TW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [CW-1:0] rate0,
    input  logic [CW-1:0] rate1,
    input  logic [TW-1:0] ticks0,
    input  logic [TW-1:0] ticks1,
    input  logic          go,
    output logic [CW-1:0] divideby,
    output logic          pulse_reset,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [1:0]    done
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last;
    logic [CW-1:0] rate_q;
    logic [TW-1:0] ticks_q;
    logic [TW-1:0] remaining;

    logic [1:0]    winner;
    logic [CW-1:0] win_rate;
    logic [TW-1:0] win_ticks;
    logic          win_zero;
    logic          last_tick;

    // On a tie the requester that did not finish most recently wins.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
        win_rate  = winner[1] ? rate1  : rate0;
        win_ticks = winner[1] ? ticks1 : ticks0;
        win_zero  = (win_rate == '0) || (win_ticks == '0);
    end

    assign last_tick = go && (remaining == TW'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next = win_zero ? DONE : ARM;
                end
            end
            ARM:     state_next = RUN;
            RUN: begin
                if (last_tick) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered datapath: latched request, tick countdown and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            divideby  <= '0;
            grant     <= 2'b00;
            done      <= 2'b00;
            last      <= 1'b1;
            rate_q    <= '0;
            ticks_q   <= '0;
            remaining <= '0;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    divideby <= '0;
                    grant    <= winner;
                    if (req != 2'b00) begin
                        rate_q  <= win_rate;
                        ticks_q <= win_ticks;
                        if (win_zero) begin
                            done <= winner;
                        end
                    end
                end
                ARM: begin
                    divideby  <= rate_q;
                    remaining <= ticks_q;
                end
                RUN: begin
                    if (go) begin
                        if (remaining == TW'(1)) begin
                            done <= grant;
                        end else begin
                            remaining <= remaining - TW'(1);
                        end
                    end
                end
                DONE: begin
                    last     <= grant[1];
                    divideby <= '0;
                    grant    <= 2'b00;
                end
                default: begin
                    divideby <= '0;
                    grant    <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        pulse_reset = reset || (state == ARM);
    end

    // The completion strobe only ever names the current owner, and only in DONE.
    a_done_in_done: assert property (@(posedge clock) disable iff (reset)
        (done != 2'b00) |-> (state == DONE));
    a_grant_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(grant));
    a_done_owner: assert property (@(posedge clock) disable iff (reset)
        (done & ~grant) == 2'b00);

endmodule

// File: tb/tb_pulse_sched.sv
// Bench for pulse_sched: a behavioural pulse divider drives go, and a timeline model
// predicts every output each cycle while directed tables and sequences probe the corners.
module tb_pulse_sched;

    localparam int CW = 26;
    localparam int TW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [CW-1:0] rate0;
    logic [CW-1:0] rate1;
    logic [TW-1:0] ticks0;
    logic [TW-1:0] ticks1;
    logic          go;
    logic          stray_go;
    logic [CW-1:0] divideby;
    logic          pulse_reset;
    logic [1:0]    grant;
    logic          busy;
    logic [1:0]    done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    pulse_sched #(.CW(CW), .TW(TW)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .rate0       (rate0),
        .rate1       (rate1),
        .ticks0      (ticks0),
        .ticks1      (ticks1),
        .go          (go),
        .divideby    (divideby),
        .pulse_reset (pulse_reset),
        .grant       (grant),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Shared divider: count restarts at 0 on its reset, go whenever the count is 0.
    logic [CW-1:0] gen_count = '0;
    always @(posedge clock) begin
        if (pulse_reset || divideby == '0 || gen_count >= divideby - 1'b1) begin
            gen_count <= '0;
        end else begin
            gen_count <= gen_count + 1'b1;
        end
    end
    assign go = ((divideby != '0) && (gen_count == '0)) || stray_go;

    // Timeline model: a grant sampled in cycle c owns cycles c+1..f, done in cycle f.
    bit            m_active = 1'b0;
    bit            m_zero = 1'b0;
    bit            m_last = 1'b1;
    logic [1:0]    m_owner = 2'b00;
    logic [CW-1:0] m_rate = '0;
    logic [TW-1:0] m_ticks = '0;
    int            m_c = 0;
    int            m_f = 0;
    bit            e_win;
    logic [1:0]    e_grant;
    logic [1:0]    e_done;
    logic          e_pr;
    logic [CW-1:0] e_div;

    function automatic bit modelInRun();
        return m_active && !m_zero && (cyc >= m_c + 2) && (cyc < m_f);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cyc, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        e_win   = m_active && (cyc >= m_c + 1) && (cyc <= m_f);
        e_grant = e_win ? m_owner : 2'b00;
        e_done  = (m_active && cyc == m_f) ? m_owner : 2'b00;
        e_pr    = reset || (m_active && !m_zero && cyc == m_c + 1);
        e_div   = (m_active && !m_zero && cyc >= m_c + 2 && cyc <= m_f) ? m_rate : '0;
        if (chk_en) begin
            checkOutput("grant", {30'd0, grant}, {30'd0, e_grant});
            checkOutput("busy", {31'd0, busy}, {31'd0, e_win});
            checkOutput("done", {30'd0, done}, {30'd0, e_done});
            checkOutput("pulse_reset", {31'd0, pulse_reset}, {31'd0, e_pr});
            checkOutput("divideby", 32'(divideby), 32'(e_div));
        end
        if (reset) begin
            m_active = 1'b0;
            m_last   = 1'b1;
        end else if (m_active) begin
            if (cyc == m_f) begin
                m_active = 1'b0;
                m_last   = m_owner[1];
            end
        end else if (req != 2'b00) begin
            m_owner  = (req == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req;
            m_rate   = m_owner[1] ? rate1 : rate0;
            m_ticks  = m_owner[1] ? ticks1 : ticks0;
            m_zero   = (m_rate == '0) || (m_ticks == '0);
            m_c      = cyc;
            m_f      = m_zero ? cyc + 1 : cyc + 3 + (int'(m_ticks) - 1) * int'(m_rate);
            m_active = 1'b1;
        end
    end

    typedef struct {
        logic [1:0] req;
        int         r0;
        int         t0;
        int         r1;
        int         t1;
        logic [1:0] exp_grant;
        int         exp_lat;
        int         exp_div;
    } vec_t;

    vec_t vecs[8];

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input int r0, input int t0,
                                 input int r1, input int t1);
        req    = r;
        rate0  = CW'(r0);
        ticks0 = TW'(t0);
        rate1  = CW'(r1);
        ticks1 = TW'(t1);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = 2'b00;
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        req = 2'b00;
        repeat (n) stepCycle();
    endtask

    // Leaves the bench at the negedge of the done cycle, or at posedge+1 on timeout.
    task automatic waitDone(input int c0, input int limit, output int lat,
                            output logic [1:0] d);
        lat = -1;
        d   = 2'b00;
        while (lat < 0 && cyc - c0 <= limit) begin
            @(negedge clock);
            if (done != 2'b00) begin
                lat = cyc - c0;
                d   = done;
            end else begin
                stepCycle();
            end
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        int c0;
        int lat;
        applyStimulus(v.req, v.r0, v.t0, v.r1, v.t1);
        c0  = cyc;
        lat = -1;
        while (lat < 0 && cyc - c0 <= 600) begin
            @(negedge clock);
            if (cyc - c0 == 1)
                checkOutput($sformatf("vec%0d grant", idx), {30'd0, grant}, {30'd0, v.exp_grant});
            if (cyc - c0 == 2 && v.exp_lat > 2)
                checkOutput($sformatf("vec%0d divideby", idx), 32'(divideby), 32'(v.exp_div));
            if (done != 2'b00) begin
                lat = cyc - c0;
                checkOutput($sformatf("vec%0d done", idx), {30'd0, done}, {30'd0, v.exp_grant});
            end else begin
                stepCycle();
            end
        end
        checkOutput($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        stepCycle();
        req = 2'b00;
        stepCycle();
    endtask

    initial begin
        int         c0;
        int         lat;
        int         gocnt;
        int         nd;
        int         drop_at[2];
        int         raise_at[2];
        logic [1:0] d;
        logic [1:0] order[4];
        logic [1:0] exp_order[4];

        reset    = 1'b1;
        stray_go = 1'b0;
        applyStimulus(2'b00, 0, 0, 0, 0);

        vecs[0] = '{2'b01, 4, 3, 0, 0, 2'b01, 11, 4};
        vecs[1] = '{2'b10, 0, 0, 1, 5, 2'b10, 7, 1};
        vecs[2] = '{2'b10, 0, 0, 7, 0, 2'b10, 1, 0};
        vecs[3] = '{2'b10, 0, 0, 0, 5, 2'b10, 1, 0};
        vecs[4] = '{2'b11, 2, 1, 3, 2, 2'b01, 3, 2};
        vecs[5] = '{2'b11, 2, 1, 3, 2, 2'b10, 6, 3};
        vecs[6] = '{2'b11, 1, 1, 5, 5, 2'b01, 3, 1};
        vecs[7] = '{2'b01, 6, 2, 0, 0, 2'b01, 9, 6};

        stepCycle();
        chk_en = 1'b1;
        stepCycle();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], i);
        end

        // Both requesters keep asking; ownership must alternate.
        doReset();
        applyStimulus(2'b11, 1, 2, 1, 2);
        exp_order   = '{2'b01, 2'b10, 2'b01, 2'b10};
        drop_at     = '{-1, -1};
        raise_at    = '{-1, -1};
        nd = 0;
        c0 = cyc;
        while (nd < 4 && cyc - c0 < 200) begin
            @(negedge clock);
            if (done != 2'b00) begin
                order[nd] = done;
                nd++;
                for (int i = 0; i < 2; i++) begin
                    if (done[i]) begin
                        drop_at[i]  = cyc + 1;
                        raise_at[i] = cyc + 3;
                    end
                end
            end
            stepCycle();
            for (int i = 0; i < 2; i++) begin
                if (cyc == drop_at[i])  req[i] = 1'b0;
                if (cyc == raise_at[i]) req[i] = 1'b1;
            end
        end
        checkOutput("alternation count", 32'(nd), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < nd)
                checkOutput($sformatf("alternation grant%0d", i), {30'd0, order[i]},
                            {30'd0, exp_order[i]});
        end
        idleCycles(20);

        // Longest wait at the fastest rate.
        doReset();
        applyStimulus(2'b01, 1, 255, 0, 0);
        c0    = cyc;
        gocnt = 0;
        do begin
            @(negedge clock);
            if (cyc - c0 >= 1 && cyc - c0 <= 256 && go) gocnt++;
            if (cyc - c0 < 257) stepCycle();
        end while (cyc - c0 < 257);
        checkOutput("ticks255 done", {30'd0, done}, 32'd1);
        checkOutput("ticks255 go count", 32'(gocnt), 32'd255);
        stepCycle();
        idleCycles(3);

        // Reset in the middle of a wait aborts it without a completion strobe.
        applyStimulus(2'b01, 3, 10, 0, 0);
        gocnt = 0;
        c0    = cyc;
        while (gocnt < 3 && cyc - c0 < 100) begin
            @(negedge clock);
            if (go) gocnt++;
            stepCycle();
        end
        checkOutput("abort go count", 32'(gocnt), 32'd3);
        doReset();
        @(negedge clock);
        checkOutput("abort grant", {30'd0, grant}, 32'd0);
        checkOutput("abort divideby", 32'(divideby), 32'd0);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clock);
            if (done != 2'b00) nd++;
            stepCycle();
        end
        checkOutput("abort stray done", 32'(nd), 32'd0);
        applyStimulus(2'b11, 2, 1, 5, 1);
        @(negedge clock);
        stepCycle();
        @(negedge clock);
        checkOutput("post-abort grant", {30'd0, grant}, 32'd1);
        stepCycle();
        idleCycles(15);

        // Request fields and req itself change mid-wait; the latched values rule.
        applyStimulus(2'b01, 2, 4, 9, 9);
        c0 = cyc;
        repeat (4) stepCycle();
        applyStimulus(2'b00, 7, 1, 9, 9);
        waitDone(c0, 100, lat, d);
        checkOutput("late change latency", 32'(lat), 32'd9);
        checkOutput("late change done", {30'd0, d}, 32'd1);
        stepCycle();
        idleCycles(3);

        // Random traffic, stray go outside RUN and occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 5)));
            reset    = ($urandom_range(0, 63) == 0);
            stray_go = !modelInRun() && ($urandom_range(0, 3) == 0);
            stepCycle();
        end
        reset    = 1'b0;
        stray_go = 1'b0;
        idleCycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
